// File: rtl/ahb_cmd2mst.sv
// AHB-Lite initiator: converts a valid/ready command stream into pipelined SINGLE transfers
// and returns read data / error status in command order through a response FIFO.
module ahb_cmd2mst #(
  parameter int unsigned P_RSP_DEPTH = 3,
  parameter logic [3:0]  P_HPROT     = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  // Command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  // Response stream
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // AHB-Lite master port
  output logic [31:0] ahb_mst_haddr,
  output logic        ahb_mst_hwrite,
  output logic [2:0]  ahb_mst_hsize,
  output logic [1:0]  ahb_mst_htrans,
  output logic [2:0]  ahb_mst_hburst,
  output logic [3:0]  ahb_mst_hprot,
  output logic        ahb_mst_hlock,
  output logic [31:0] ahb_mst_hwdata,
  input  logic [31:0] ahb_mst_hrdata,
  input  logic        ahb_mst_hready,
  input  logic [1:0]  ahb_mst_hresp
);

  localparam int unsigned PtrW = (P_RSP_DEPTH > 1) ? $clog2(P_RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(P_RSP_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  // Address-phase slot
  logic        a_vld_q, a_vld_d;
  logic [31:0] a_addr_q;
  logic        a_write_q;
  logic [2:0]  a_size_q;
  logic [31:0] a_wdata_q;
  // Data-phase slot
  logic        d_vld_q, d_vld_d;
  logic        d_write_q;
  logic [31:0] hwdata_q;
  // Bus control
  logic [1:0]  htrans_q, htrans_d;
  logic        cancel_q, cancel_d;
  // Response FIFO
  rsp_t            rsp_mem_q [P_RSP_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] rsp_cnt_q, rsp_cnt_d;

  logic            hready;
  logic            bus_err;
  logic [SumW-1:0] inflight;
  logic            credit;
  logic            advance;
  logic            cmd_fire;
  logic            a_to_d;
  logic            d_done;
  logic            rsp_pop;
  rsp_t            rsp_wr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(P_RSP_DEPTH - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  assign hready  = ahb_mst_hready;
  assign bus_err = (ahb_mst_hresp != 2'b00);

  always_comb begin
    // Registered occupancy only; a pop this cycle frees a credit next cycle.
    inflight  = SumW'(a_vld_q) + SumW'(d_vld_q) + SumW'(rsp_cnt_q);
    credit    = (inflight < SumW'(P_RSP_DEPTH));
    advance   = hready & ~cancel_q;
    // A waited data phase freezes intake even when A is empty.
    cmd_ready = (~a_vld_q | advance) & (hready | ~d_vld_q) & credit;
    cmd_fire  = cmd_valid & cmd_ready;
    a_to_d    = a_vld_q & advance;
    d_done    = d_vld_q & hready;
    rsp_pop   = rsp_valid & rsp_ready;
  end

  always_comb begin
    a_vld_d = cmd_fire | (a_vld_q & ~a_to_d);
    d_vld_d = a_to_d | (d_vld_q & ~d_done);

    // First ERROR cycle raises cancel; the completing ERROR cycle drops it.
    cancel_d = cancel_q;
    if (cancel_q) begin
      cancel_d = ~hready;
    end else if (d_vld_q && !hready && bus_err) begin
      cancel_d = 1'b1;
    end

    htrans_d = (a_vld_d && !cancel_d) ? HtransNonseq : HtransIdle;
  end

  always_comb begin
    rsp_wr.err   = bus_err;
    rsp_wr.rdata = (bus_err || d_write_q) ? 32'h0 : ahb_mst_hrdata;

    wr_ptr_d  = d_done ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = rsp_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    rsp_cnt_d = rsp_cnt_q + CntW'(d_done) - CntW'(rsp_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_vld_q   <= 1'b0;
      a_addr_q  <= '0;
      a_write_q <= 1'b0;
      a_size_q  <= '0;
      a_wdata_q <= '0;
      d_vld_q   <= 1'b0;
      d_write_q <= 1'b0;
      hwdata_q  <= '0;
      htrans_q  <= HtransIdle;
      cancel_q  <= 1'b0;
    end else begin
      a_vld_q  <= a_vld_d;
      d_vld_q  <= d_vld_d;
      htrans_q <= htrans_d;
      cancel_q <= cancel_d;
      if (cmd_fire) begin
        a_addr_q  <= cmd_addr;
        a_write_q <= cmd_write;
        a_size_q  <= cmd_size;
        a_wdata_q <= cmd_wdata;
      end
      if (a_to_d) begin
        d_write_q <= a_write_q;
        // hwdata only changes when a new write enters the data phase.
        if (a_write_q) begin
          hwdata_q <= a_wdata_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(P_RSP_DEPTH); i++) begin
        rsp_mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (d_done) begin
        rsp_mem_q[wr_ptr_q] <= rsp_wr;
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  assign rsp_valid = (rsp_cnt_q != '0);
  assign rsp_rdata = rsp_mem_q[rd_ptr_q].rdata;
  assign rsp_err   = rsp_mem_q[rd_ptr_q].err;

  assign ahb_mst_haddr  = a_addr_q;
  assign ahb_mst_hwrite = a_write_q;
  assign ahb_mst_hsize  = a_size_q;
  assign ahb_mst_htrans = htrans_q;
  assign ahb_mst_hburst = 3'b000;
  assign ahb_mst_hprot  = P_HPROT;
  assign ahb_mst_hlock  = 1'b0;
  assign ahb_mst_hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb_cmd2mst.sv
// Directed bench for ahb_cmd2mst: per-cycle vector table plus hand sequences for
// credit back-pressure and asynchronous reset during a data phase.
module tb_ahb_cmd2mst;

  localparam int unsigned Depth = 4;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam int NumVec = 28;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata, hrdata, hrdata_drv, dph_addr;
  logic        hwrite, hlock, hready;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans, hresp;
  logic [3:0]  hprot;
  logic        slave_auto;

  int n_cmp  = 0;
  int n_fail = 0;
  int acc;
  int n_got;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  typedef struct {
    logic        cv;
    logic [31:0] ca;
    logic        cw;
    logic [2:0]  cs;
    logic [31:0] cd;
    logic        hr;
    logic [1:0]  hp;
    logic [31:0] hd;
    logic        e_cr;
    logic        e_ns;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [2:0]  e_sz;
    logic        e_wc;
    logic [31:0] e_wd;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs[NumVec];

  ahb_cmd2mst #(
    .P_RSP_DEPTH(Depth),
    .P_HPROT    (4'b0011)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_write     (cmd_write),
    .cmd_size      (cmd_size),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .ahb_mst_haddr (haddr),
    .ahb_mst_hwrite(hwrite),
    .ahb_mst_hsize (hsize),
    .ahb_mst_htrans(htrans),
    .ahb_mst_hburst(hburst),
    .ahb_mst_hprot (hprot),
    .ahb_mst_hlock (hlock),
    .ahb_mst_hwdata(hwdata),
    .ahb_mst_hrdata(hrdata),
    .ahb_mst_hready(hready),
    .ahb_mst_hresp (hresp)
  );

  always #5 clk = ~clk;

  // Simple slave: read data encodes the address of the transfer in its data phase.
  always @(posedge clk) begin
    if (hready && htrans == 2'b10) dph_addr <= haddr;
  end
  assign hrdata = slave_auto ? {16'hBEEF, dph_addr[15:0]} : hrdata_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            cv  ca            cw cs    cd             hr hp    hd
    //            cr  ns addr        wr sz    wc wd           rv rd            err
    vecs[0]  = '{Y, 32'h1000, N, 3'd2, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, Y, 32'h0, N, 32'h0, N};
    vecs[1]  = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, Y, 32'h1000, N, 3'd2, N, 32'h0, N, 32'h0, N};
    vecs[2]  = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'hDEADBEEF,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, N, 32'h0, N};
    vecs[3]  = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, Y, 32'hDEADBEEF, N};
    vecs[4]  = '{Y, 32'h0, Y, 3'd2, 32'h11, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, N, 32'h0, N};
    vecs[5]  = '{Y, 32'h4, Y, 3'd2, 32'h22, Y, 2'd0, 32'h0,
                 Y, Y, 32'h0, Y, 3'd2, N, 32'h0, N, 32'h0, N};
    vecs[6]  = '{Y, 32'h8, Y, 3'd2, 32'h33, Y, 2'd0, 32'h0,
                 Y, Y, 32'h4, Y, 3'd2, Y, 32'h11, N, 32'h0, N};
    vecs[7]  = '{Y, 32'hC, Y, 3'd2, 32'h44, Y, 2'd0, 32'h0,
                 Y, Y, 32'h8, Y, 3'd2, Y, 32'h22, Y, 32'h0, N};
    vecs[8]  = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, Y, 32'hC, Y, 3'd2, Y, 32'h33, Y, 32'h0, N};
    vecs[9]  = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, Y, 32'h44, Y, 32'h0, N};
    vecs[10] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, Y, 32'h44, Y, 32'h0, N};
    vecs[11] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, Y, 32'h44, N, 32'h0, N};
    vecs[12] = '{Y, 32'h2000, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, N, 32'h0, N};
    vecs[13] = '{Y, 32'h2004, N, 3'd1, 32'h0, Y, 2'd0, 32'h0,
                 Y, Y, 32'h2000, N, 3'd0, N, 32'h0, N, 32'h0, N};
    vecs[14] = '{N, 32'h0, N, 3'd0, 32'h0, N, 2'd0, 32'h0,
                 N, Y, 32'h2004, N, 3'd1, N, 32'h0, N, 32'h0, N};
    vecs[15] = '{N, 32'h0, N, 3'd0, 32'h0, N, 2'd0, 32'h0,
                 N, Y, 32'h2004, N, 3'd1, N, 32'h0, N, 32'h0, N};
    vecs[16] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'hCAFE0001,
                 Y, Y, 32'h2004, N, 3'd1, N, 32'h0, N, 32'h0, N};
    vecs[17] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'hCAFE0002,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, Y, 32'hCAFE0001, N};
    vecs[18] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, Y, 32'hCAFE0002, N};
    vecs[19] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, N, 32'h0, N};
    vecs[20] = '{Y, 32'h10, Y, 3'd2, 32'hAA55, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, N, 32'h0, N};
    vecs[21] = '{Y, 32'h14, N, 3'd2, 32'h0, Y, 2'd0, 32'h0,
                 Y, Y, 32'h10, Y, 3'd2, N, 32'h0, N, 32'h0, N};
    vecs[22] = '{N, 32'h0, N, 3'd0, 32'h0, N, 2'd1, 32'h0,
                 N, Y, 32'h14, N, 3'd2, Y, 32'hAA55, N, 32'h0, N};
    vecs[23] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd1, 32'h0,
                 N, N, 32'h0, N, 3'd0, Y, 32'hAA55, N, 32'h0, N};
    vecs[24] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, Y, 32'h14, N, 3'd2, N, 32'h0, Y, 32'h0, Y};
    vecs[25] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h12345678,
                 Y, N, 32'h0, N, 3'd0, Y, 32'hAA55, N, 32'h0, N};
    vecs[26] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, Y, 32'h12345678, N};
    vecs[27] = '{N, 32'h0, N, 3'd0, 32'h0, Y, 2'd0, 32'h0,
                 Y, N, 32'h0, N, 3'd0, N, 32'h0, N, 32'h0, N};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0;
    cmd_wdata = '0; rsp_ready = 1'b1; hready = 1'b1; hresp = 2'b00; hrdata_drv = '0;
    slave_auto = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check("reset htrans", 32'(htrans), 32'h0);
    check("reset haddr", haddr, 32'h0);
    check("reset hwdata", hwdata, 32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset cmd_ready", 32'(cmd_ready), 32'h1);
    check("const hburst/hprot/hlock", {24'h0, hburst, hprot, hlock}, {24'h0, 3'b000, 4'b0011, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    // Table-driven per-cycle vectors
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      cmd_valid = vecs[i].cv; cmd_addr = vecs[i].ca; cmd_write = vecs[i].cw;
      cmd_size = vecs[i].cs; cmd_wdata = vecs[i].cd;
      hready = vecs[i].hr; hresp = vecs[i].hp; hrdata_drv = vecs[i].hd;
      #1;
      check($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_cr));
      check($sformatf("v%0d htrans", i), 32'(htrans), vecs[i].e_ns ? 32'h2 : 32'h0);
      if (vecs[i].e_ns) begin
        check($sformatf("v%0d haddr", i), haddr, vecs[i].e_addr);
        check($sformatf("v%0d hwrite", i), 32'(hwrite), 32'(vecs[i].e_wr));
        check($sformatf("v%0d hsize", i), 32'(hsize), 32'(vecs[i].e_sz));
      end
      if (vecs[i].e_wc) check($sformatf("v%0d hwdata", i), hwdata, vecs[i].e_wd);
      check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        check($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].e_rd);
        check($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].e_err));
      end
    end

    // Credit limit with rsp_ready low
    slave_auto = 1'b1; rsp_ready = 1'b0; hready = 1'b1; hresp = 2'b00; acc = 0; n_got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 3'd2;
      cmd_addr = 32'h100 + 32'(acc) * 32'd4;
      #1;
      if (cmd_ready) begin
        exp_q.push_back({16'hBEEF, cmd_addr[15:0]});
        acc++;
      end
    end
    check("credit accepted count", 32'(acc), 32'(Depth));
    check("credit stall cmd_ready", 32'(cmd_ready), 32'h0);
    check("credit full rsp_valid", 32'(rsp_valid), 32'h1);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("credit cmd_ready in pop cycle", 32'(cmd_ready), 32'h0);
    if (rsp_valid) begin
      exp_v = exp_q.pop_front();
      check("credit rsp first", rsp_rdata, exp_v);
      n_got++;
    end
    @(negedge clk);
    #1;
    check("credit cmd_ready after pop", 32'(cmd_ready), 32'h1);
    if (rsp_valid) begin
      exp_v = exp_q.pop_front();
      check("credit rsp second", rsp_rdata, exp_v);
      n_got++;
    end
    if (cmd_ready) exp_q.push_back({16'hBEEF, cmd_addr[15:0]});
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("credit extra response", rsp_rdata, 32'hFFFFFFFF);
        end else begin
          exp_v = exp_q.pop_front();
          check($sformatf("credit drain rdata %0d", n_got), rsp_rdata, exp_v);
          check($sformatf("credit drain err %0d", n_got), 32'(rsp_err), 32'h0);
        end
        n_got++;
      end
    end
    check("credit total responses", 32'(n_got), 32'(Depth + 1));

    // Asynchronous reset during a waited data phase
    slave_auto = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h3000; cmd_write = 1'b0; cmd_size = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    hready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async reset htrans", 32'(htrans), 32'h0);
    check("async reset haddr", haddr, 32'h0);
    check("async reset hwdata", hwdata, 32'h0);
    check("async reset rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0; hready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-reset idle rsp_valid %0d", c), 32'(rsp_valid), 32'h0);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h4000;
    #1;
    check("post-reset cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("post-reset htrans", 32'(htrans), 32'h2);
    check("post-reset haddr", haddr, 32'h4000);
    @(negedge clk);
    hrdata_drv = 32'h0BADF00D;
    n_got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid && n_got == 0) begin
        check("post-reset rsp_rdata", rsp_rdata, 32'h0BADF00D);
        n_got = 1;
      end
    end
    check("post-reset response seen", 32'(n_got), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_cmd2mst.md
# ahb_cmd2mst

Single-clock AHB-Lite initiator that turns a simple valid/ready command stream (address, direction, size, write data) into pipelined AHB single transfers on an AHB master port, and returns read data and error status on a valid/ready response stream. It sits on the initiator side of our AHB mirrored-slave ports, so internal engines such as DMA, test sequencers and boot loaders can drive a slave or interconnect without implementing AHB phase timing themselves.

## Interface
- P_RSP_DEPTH, 3, response FIFO depth and in-flight limit; legal range 3..8.
- P_HPROT, 4'b0011, constant driven on ahb_mst_hprot.
- clk  in  1  sole clock; everything is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  32  byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  3  HSIZE encoding; only 0..2 are legal.
- cmd_wdata  in  32  write data, captured with the command.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = slave returned ERROR.
- ahb_mst_haddr / hwrite / hsize  out  32/1/3  address-phase controls.
- ahb_mst_htrans  out  2  IDLE (00) or NONSEQ (10) only.
- ahb_mst_hburst  out  3  constant 3'b000 (SINGLE).
- ahb_mst_hprot  out  4  P_HPROT.
- ahb_mst_hlock  out  1  constant 0.
- ahb_mst_hwdata  out  32  data-phase write data.
- ahb_mst_hrdata  in  32  read data.
- ahb_mst_hready  in  1  transfer-done / bus-ready.
- ahb_mst_hresp  in  2  00 = OKAY, 01 = ERROR; other codes are treated as ERROR.

## Operation
- Two pipeline slots: A (address phase: addr, write, size, wdata) and D (data phase: write, wdata). A response FIFO of depth P_RSP_DEPTH sits behind them.
- All AHB outputs come directly from registers. htrans = NONSEQ iff A is valid and no error cancel is in progress; otherwise IDLE.
- Advance when hready=1: D completes and pushes a response. A moves to D. A new command, if accepted this cycle, loads A.
- cmd_ready = (~a_vld | (hready & ~cancel)) & (a_vld + d_vld + rsp_cnt < P_RSP_DEPTH), using registered counts. No same-cycle credit is returned from rsp pops. This limit guarantees the FIFO never overflows, because the slave cannot be stalled.
- Response push on completion: rdata = hrdata for reads and 0 for writes; err = (hresp != 00). On an error, rdata = 0.
- ERROR handling is two-cycle. On seeing hresp=ERROR with hready=0 while D is valid, set cancel:
  - The next cycle drives htrans=IDLE while A is kept.
  - When the error's hready=1 cycle completes D with err=1, clear cancel.
  - A is re-issued as NONSEQ on the following cycle.
- Write data is never re-sent for a cancelled command, because it had not yet reached the data phase.
- hwdata holds its value after a write completes until the next write enters D.
- Reset: htrans=00, haddr=0, hwrite=0, hsize=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all slots and FIFO empty, cancel=0. cmd_ready=1 in the first cycle after reset.
- Reset asserted mid-transfer abandons in-flight transfers. No responses are produced for them.

## Timing
- Command accepted at edge N: NONSEQ is visible in cycle N+1. The data phase is cycle N+2 with hwdata valid. With a zero-wait slave, rsp_valid is seen in cycle N+3.
- Back-to-back throughput is one transfer per cycle with zero-wait slaves while rsp_ready=1. It drops when the in-flight limit is hit.
- Wait states (hready=0) freeze A, D, all AHB outputs and cmd_ready=0. The response FIFO still pops.
- Responses are returned strictly in command order.
- FIFO full and rsp_ready=0: cmd_ready=0 until a pop frees a credit, one cycle after the pop.

## Test plan
- Single read at 0x0000_1000, slave returns 0xDEAD_BEEF with zero waits: NONSEQ one cycle after acceptance; rsp rdata=0xDEAD_BEEF, err=0, three cycles after acceptance.
- Four back-to-back writes (0x0/0x4/0x8/0xC, data 0x11..0x44), rsp_ready=1, zero waits: four consecutive NONSEQ cycles; each hwdata appears one cycle after its address; four err=0 responses in order.
- Read with 2 wait states: haddr/htrans held constant and cmd_ready=0 for 2 cycles; the response arrives 2 cycles later than the zero-wait case.
- Write to 0x10 then read 0x14, slave returns ERROR on the write: IDLE driven during the second error cycle; 0x14 re-issued as NONSEQ one cycle later; responses are {err=1} then {err=0, correct data}.
- rsp_ready=0 with a stream of reads: exactly P_RSP_DEPTH commands accepted, then cmd_ready=0. After rsp_ready rises, one credit returns per pop, and no response is lost or duplicated.
- Assert reset during a data phase: all outputs return to reset values asynchronously, no rsp_valid follows, and a new command works normally afterwards.
